// File: rtl/image_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : image_receiver_pkg
//  Description : Shared protocol definitions for the image link receiver:
//                end-of-frame marker, default frame size and the state
//                encodings of the frame FSM and the UART receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package image_receiver_pkg;

   // A single byte of this value closes a frame; second bytes never carry it.
   localparam logic [7:0] END_MARKER           = 8'hFF;
   localparam int         DEFAULT_FRAME_PIXELS = 3072;

   // Frame FSM states.
   typedef enum logic [2:0] {
      W_ARM = 3'd0,   // idle, waiting for arm
      W_FB  = 3'd1,   // waiting for first (high) byte of a pixel or the marker
      W_SB  = 3'd2,   // waiting for second (low) byte of a pixel
      WRITE = 3'd3,   // one-cycle frame-buffer write
      END   = 3'd4    // one-cycle end-of-frame
   } rx_fsm_t;

   // UART receiver states.
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } uart_state_t;

   function automatic logic is_end_marker(input logic [7:0] b);
      return (b == END_MARKER);
   endfunction

endpackage
`default_nettype wire

// File: rtl/image_receiver_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. Two-flop synchroniser on the serial
//                input, start bit re-checked at its centre, data bits sampled
//                at bit centres (LSB first). A byte is reported only if the
//                stop bit is high.
//  Ports       : i_Clock      system clock
//                rst          synchronous active-high reset
//                i_Rx_Serial  serial input, idle high
//                o_Rx_DV      one-cycle strobe, byte valid
//                o_Rx_Byte    received byte, valid with o_Rx_DV
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
   import image_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
)(
   input  logic       i_Clock,
   input  logic       rst,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_DV,
   output logic [7:0] o_Rx_Byte
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] C_BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] C_HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);

   uart_state_t      state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       byte_q, byte_d;
   logic             dv_q, dv_d;

   always_comb begin
      state_d = state_q;
      sync1_d = i_Rx_Serial;
      sync2_d = sync1_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      dv_d    = 1'b0;

      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (!sync2_q) begin
               state_d = RX_START;
            end
         end
         RX_START: begin
            // A low level still present mid-bit confirms a real start bit;
            // a glitch returns to idle.
            if (cnt_q == C_HALF) begin
               cnt_d   = '0;
               state_d = sync2_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (cnt_q == C_BIT_LAST) begin
               cnt_d  = '0;
               byte_d = {sync2_q, byte_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (cnt_q == C_BIT_LAST) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               dv_d    = sync2_q;   // framing error drops the byte
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (rst) begin
         state_q <= RX_IDLE;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         dv_q    <= dv_d;
      end
   end

   assign o_Rx_DV   = dv_q;
   assign o_Rx_Byte = byte_q;

endmodule
`default_nettype wire

// File: rtl/image_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : image_receiver
//  Description : Far end of the image link. Deserialises the UART byte stream
//                (first byte, second byte per pixel; frame closed by 0xFF),
//                rebuilds each pixel and writes it into the dual-image frame
//                buffer. Image 1 lives at offset 0, image 0 at FRAME_PIXELS.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                Rx_data         UART serial input, idle high
//                arm             pulse: accept the next frame
//                image_select    1: image 1 (offset 0), 0: image 0
//                wr_en           one-cycle write strobe
//                addr_out        write address, valid with wr_en
//                pixel_data      write data, valid with wr_en
//                busy            frame reception in progress
//                frame_done      one-cycle end-of-frame pulse
//                frame_error     sticky status of last frame, cleared on arm
//  Options     : RX_TIMEOUT_EN   abort a frame after 32 idle bit times
//  Revision    : 1.0  initial release
// ============================================================================
module image_receiver
   import image_receiver_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
   parameter int ADDR_W       = 13,
   parameter int PIX_W        = 3     // 1..16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              Rx_data,
   input  logic              arm,
   input  logic              image_select,
   output logic              wr_en,
   output logic [ADDR_W-1:0] addr_out,
   output logic [PIX_W-1:0]  pixel_data,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_error
);

   localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
   localparam int HI_W  = (PIX_W > 8) ? (PIX_W - 8) : 0;
   localparam logic [CNT_W-1:0]  C_FULL   = CNT_W'(FRAME_PIXELS);
   localparam logic [ADDR_W-1:0] C_IMG0_OFFSET = ADDR_W'(FRAME_PIXELS);

   // ------------------------------------------------------------------
   // Byte source
   // ------------------------------------------------------------------
   logic       rx_dv;
   logic [7:0] rx_byte;

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_rx (
      .i_Clock     (clk),
      .rst         (rst),
      .i_Rx_Serial (Rx_data),
      .o_Rx_DV     (rx_dv),
      .o_Rx_Byte   (rx_byte)
   );

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   rx_fsm_t           state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              w_marker;
   logic              w_full;
   logic              w_timeout;
   logic [PIX_W-1:0]  w_pix;

   assign w_marker = is_end_marker(rx_byte);
   assign w_full   = (count_q == C_FULL);

   // ------------------------------------------------------------------
   // Pixel assembly: only pixels wider than a byte need the first byte,
   // so the high-byte latch exists only in that configuration.
   // ------------------------------------------------------------------
   if (HI_W > 0) begin : g_hi_byte
      logic [HI_W-1:0] hi_q, hi_d;

      always_comb begin
         hi_d = hi_q;
         if (state_q == W_FB && rx_dv && !w_marker && !w_full) begin
            hi_d = rx_byte[HI_W-1:0];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            hi_q <= '0;
         end else begin
            hi_q <= hi_d;
         end
      end

      assign w_pix = {hi_q, rx_byte};
   end else begin : g_lo_only
      assign w_pix = rx_byte[PIX_W-1:0];
   end

   // ------------------------------------------------------------------
   // Optional link-stall timeout
   // ------------------------------------------------------------------
`ifdef RX_TIMEOUT_EN
   localparam int IDLE_LIMIT = 32 * CLKS_PER_BIT;
   localparam int IDLE_W     = $clog2(IDLE_LIMIT);
   // The counter restarts the cycle after rx_dv and the registered
   // frame_done lands one cycle after the decision, hence LIMIT-2.
   localparam logic [IDLE_W-1:0] C_IDLE_LAST = IDLE_W'(IDLE_LIMIT - 2);

   logic [IDLE_W-1:0] idle_q, idle_d;

   always_comb begin
      idle_d = idle_q;
      if (!busy_q || rx_dv) begin
         idle_d = '0;
      end else if (idle_q != C_IDLE_LAST) begin
         idle_d = idle_q + IDLE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end

   assign w_timeout = busy_q && (idle_q == C_IDLE_LAST);
`else
   assign w_timeout = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Frame FSM next-state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wr_en_d = 1'b0;
      addr_d  = addr_q;
      pix_d   = pix_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;

      case (state_q)
         W_ARM: begin
            if (arm) begin
               count_d = '0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = W_FB;
            end
         end
         W_FB: begin
            if (w_timeout) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = END;
            end else if (rx_dv) begin
               if (w_marker) begin
                  if (!w_full) begin
                     err_d = 1'b1;   // short frame
                  end
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = END;
               end else if (w_full) begin
                  err_d = 1'b1;      // overlong frame, byte dropped
               end else begin
                  state_d = W_SB;
               end
            end
         end
         W_SB: begin
            if (w_timeout) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = END;
            end else if (rx_dv) begin
               if (w_marker) begin
                  // Marker in a second-byte slot means the stream lost
                  // pixel alignment; resynchronise on the next byte.
                  err_d   = 1'b1;
                  state_d = W_FB;
               end else begin
                  wr_en_d = 1'b1;
                  pix_d   = w_pix;
                  addr_d  = ADDR_W'(count_q) +
                            (image_select ? '0 : C_IMG0_OFFSET);
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            count_d = count_q + CNT_W'(1);
            state_d = W_FB;
         end
         END: begin
            state_d = W_ARM;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = W_ARM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= W_ARM;
         count_q <= '0;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         pix_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         pix_q   <= pix_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign addr_out    = addr_q;
   assign pixel_data  = pix_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign frame_error = err_q;

endmodule
`default_nettype wire

// File: tb/tb_image_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_receiver
//  Description : Scoreboard bench for image_receiver. Stimulus drives serial
//                UART bytes and queues the writes / frame results it expects;
//                a monitor pops and compares on every wr_en and frame_done.
//                Scaled configuration: 4 clk/bit, 24-pixel frames, 5-bit
//                address so image 0 wraps modulo 32.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_image_receiver;
   import image_receiver_pkg::*;

   localparam int CPB  = 4;
   localparam int FP   = 24;
   localparam int AW   = 5;
   localparam int PW   = 3;
   localparam int AMOD = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          Rx_data;
   logic          arm;
   logic          image_select;
   logic          wr_en;
   logic [AW-1:0] addr_out;
   logic [PW-1:0] pixel_data;
   logic          busy;
   logic          frame_done;
   logic          frame_error;

   image_receiver #(
      .CLKS_PER_BIT (CPB),
      .FRAME_PIXELS (FP),
      .ADDR_W       (AW),
      .PIX_W        (PW)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .Rx_data      (Rx_data),
      .arm          (arm),
      .image_select (image_select),
      .wr_en        (wr_en),
      .addr_out     (addr_out),
      .pixel_data   (pixel_data),
      .busy         (busy),
      .frame_done   (frame_done),
      .frame_error  (frame_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int exp_addr[$];
   int exp_data[$];
   int exp_err[$];
   int last_dv_cyc = 0;
   int done_cyc    = 0;
   logic done_seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      if (u_dut.rx_dv) last_dv_cyc = cyc;
      if (wr_en) begin
         if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %0d, expected none",
                     addr_out, pixel_data);
         end else begin
            check("wr_addr", int'(addr_out), exp_addr.pop_front());
            check("wr_data", int'(pixel_data), exp_data.pop_front());
         end
      end
      if (frame_done) begin
         done_seen = 1'b1;
         done_cyc  = cyc;
         if (exp_err.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_done: got frame_error %0d, expected no pulse",
                     frame_error);
         end else begin
            check("frame_error_at_done", int'(frame_error), exp_err.pop_front());
         end
         check("busy_at_done", int'(busy), 0);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic send_byte(input logic [7:0] b);
      Rx_data = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         Rx_data = b[i];
         repeat (CPB) @(negedge clk);
      end
      Rx_data = 1'b1;
      repeat (2 * CPB) @(negedge clk);   // stop bit + one idle bit
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      @(negedge clk);
   endtask

   // Pixels start..start+n-1 as {00, lo_or | i%8}; data expected is i%8.
   task automatic send_pixels(input int sel, input int start, input int n,
                              input logic [7:0] lo_or);
      for (int i = start; i < start + n; i++) begin
         exp_addr.push_back(sel != 0 ? (i % AMOD) : ((FP + i) % AMOD));
         exp_data.push_back(i % 8);
         send_byte(8'h00);
         send_byte(lo_or | 8'(i % 8));
      end
   endtask

   task automatic end_frame(input int err);
      exp_err.push_back(err);
      send_byte(END_MARKER);
   endtask

   task automatic drain(input string name);
      repeat (20) @(negedge clk);
      check({name, "_writes_outstanding"}, exp_addr.size(), 0);
      check({name, "_done_outstanding"}, exp_err.size(), 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      rst          = 1'b1;
      Rx_data      = 1'b1;
      arm          = 1'b0;
      image_select = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_wr_en", int'(wr_en), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_frame_error", int'(frame_error), 0);
      check("rst_addr", int'(addr_out), 0);
      check("rst_pixel", int'(pixel_data), 0);
      check("rst_state", int'(u_dut.state_q), int'(W_ARM));

      // 1: full frame into image 1
      image_select = 1'b1;
      pulse_arm();
      check("t1_busy_after_arm", int'(busy), 1);
      send_pixels(1, 0, FP, 8'h00);
      end_frame(0);
      drain("t1");

      // 2: image 0, addresses offset by FP and wrapping modulo 32;
      //    upper bits of the second byte must not leak into the data
      image_select = 1'b0;
      pulse_arm();
      send_pixels(0, 0, FP, 8'hF0);
      end_frame(0);
      drain("t2");

      // 3: short frame
      image_select = 1'b1;
      pulse_arm();
      send_pixels(1, 0, 10, 8'h00);
      end_frame(1);
      drain("t3");
      check("t3_busy_after", int'(busy), 0);
      check("t3_error_sticky", int'(frame_error), 1);

      // 4: arm clears the sticky error; desync pair; arm while busy ignored
      pulse_arm();
      check("t4_error_cleared", int'(frame_error), 0);
      send_pixels(1, 0, 3, 8'h00);
      send_byte(8'h00);
      send_byte(END_MARKER);
      check("t4_desync_error", int'(frame_error), 1);
      pulse_arm();
      check("t4_arm_ignored_err", int'(frame_error), 1);
      check("t4_arm_ignored_busy", int'(busy), 1);
      exp_addr.push_back(3);
      exp_data.push_back(5);
      send_byte(8'h00);
      send_byte(8'h05);
      send_pixels(1, 4, FP - 4, 8'h00);
      end_frame(1);
      drain("t4");

      // 4b: one pixel beyond a full frame is dropped and flags the frame
      pulse_arm();
      send_pixels(1, 0, FP, 8'h00);
      send_byte(8'h00);
      send_byte(8'h03);
      end_frame(1);
      drain("t4b");

      // 5: bytes before arm are discarded; rst mid-frame
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(END_MARKER);
      drain("t5_prearm");
      pulse_arm();
      send_pixels(1, 0, 5, 8'h00);
      send_byte(8'h00);
      fork
         send_byte(8'h03);
         begin
            repeat (5 * CPB) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check("t5_rst_wr_en", int'(wr_en), 0);
            check("t5_rst_busy", int'(busy), 0);
            check("t5_rst_done", int'(frame_done), 0);
            check("t5_rst_error", int'(frame_error), 0);
            check("t5_rst_addr", int'(addr_out), 0);
            check("t5_rst_pixel", int'(pixel_data), 0);
            check("t5_rst_state", int'(u_dut.state_q), int'(W_ARM));
         end
      join
      repeat (12 * CPB) @(negedge clk);
      drain("t5_after_rst");
      pulse_arm();
      send_pixels(1, 0, FP, 8'h00);
      end_frame(0);
      drain("t5_full");

      // 6: stalled link
      pulse_arm();
      send_pixels(1, 0, 3, 8'h00);
`ifdef RX_TIMEOUT_EN
      exp_err.push_back(1);
      done_seen = 1'b0;
      for (int i = 0; i < 32 * CPB + 200 && !done_seen; i++) @(negedge clk);
      check("t6_timeout_seen", int'(done_seen), 1);
      check("t6_timeout_delay", done_cyc - last_dv_cyc, 32 * CPB);
      drain("t6");
`else
      done_seen = 1'b0;
      repeat (32 * CPB + 100) @(negedge clk);
      check("t6_busy_held", int'(busy), 1);
      check("t6_no_done", int'(done_seen), 0);
      end_frame(1);
      drain("t6");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
